// File: rtl/bsg_dmc_ui_responder.sv
// bsg_dmc_ui_responder: memory-controller side of the DMC app (UI) interface.
// Accepts write/read bursts against a small internal beat memory and returns
// read bursts after a fixed, programmable latency.
// Optional feature: define BSG_DMC_UI_RESPONDER_ERR_CHECK_EN to generate the
// sticky error_o flag (wdf_end misuse, illegal command). Undefined: error_o = 0.
module bsg_dmc_ui_responder #(
  parameter int unsigned ui_addr_width_p = 28,
  parameter int unsigned ui_data_width_p = 32,
  parameter int unsigned ui_burst_len_p  = 4,
  parameter int unsigned mem_els_p       = 64,
  parameter int unsigned rd_latency_p    = 3
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [ui_addr_width_p-1:0]   app_addr_i,
  input  logic [2:0]                   app_cmd_i,
  input  logic                         app_en_i,
  output logic                         app_rdy_o,
  input  logic                         app_wdf_wren_i,
  input  logic [ui_data_width_p-1:0]   app_wdf_data_i,
  input  logic [ui_data_width_p/8-1:0] app_wdf_mask_i,
  input  logic                         app_wdf_end_i,
  output logic                         app_wdf_rdy_o,
  output logic                         app_rd_data_valid_o,
  output logic [ui_data_width_p-1:0]   app_rd_data_o,
  output logic                         app_rd_data_end_o,
  output logic                         error_o
);

  localparam int unsigned mask_w   = ui_data_width_p / 8;
  localparam int unsigned byte_w   = $clog2(mask_w);
  localparam int unsigned burst_w  = $clog2(ui_burst_len_p);
  localparam int unsigned cnt_w    = (burst_w > 0) ? burst_w : 1;
  localparam int unsigned idx_w    = $clog2(mem_els_p);
  localparam int unsigned lat_w    = (rd_latency_p > 1) ? $clog2(rd_latency_p) : 1;
  localparam int unsigned lat_last = (rd_latency_p > 0) ? rd_latency_p - 1 : 0;
  localparam int unsigned cnt_last = ui_burst_len_p - 1;

  localparam logic [1:0] st_idle    = 2'd0;
  localparam logic [1:0] st_write   = 2'd1;
  localparam logic [1:0] st_rd_wait = 2'd2;
  localparam logic [1:0] st_read    = 2'd3;

  localparam logic [2:0] cmd_write = 3'b000;
  localparam logic [2:0] cmd_read  = 3'b001;

  logic [1:0]                 state_r, state_n;
  logic [cnt_w-1:0]           cnt_r, cnt_n;
  logic [lat_w-1:0]           lat_r, lat_n;
  logic [idx_w-1:0]           base_r, base_n;
  logic                       rdy_r, wdf_rdy_r;
  logic                       rd_valid_r, rd_valid_n;
  logic [ui_data_width_p-1:0] rd_data_r, rd_data_n;
  logic                       rd_end_r, rd_end_n;
  logic [idx_w-1:0]           cmd_base;
  logic [idx_w-1:0]           rd_idx;
  logic [idx_w-1:0]           wr_idx;
  logic                       mem_we;
  logic                       cnt_is_last;
  logic [cnt_w-1:0]           cnt_inc;

  logic [ui_data_width_p-1:0] mem [mem_els_p];

`ifdef BSG_DMC_UI_RESPONDER_ERR_CHECK_EN
  logic error_r, error_n;
  logic unused_addr;
  assign unused_addr = ^app_addr_i;
`else
  logic unused_inputs;
  assign unused_inputs = ^{app_addr_i, app_wdf_end_i};
`endif

  // Burst-aligned beat index of the presented command address, wrapped to memory depth
  assign cmd_base    = idx_w'(app_addr_i >> byte_w) & ~idx_w'(cnt_last);
  assign wr_idx      = base_r + idx_w'(cnt_r);
  assign cnt_is_last = (cnt_r == cnt_w'(cnt_last));
  assign cnt_inc     = cnt_r + cnt_w'(1);

  // Next-state, beat counting, read beat selection and error detection
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    lat_n      = lat_r;
    base_n     = base_r;
    rd_valid_n = 1'b0;
    rd_end_n   = 1'b0;
    rd_data_n  = rd_data_r;
    rd_idx     = base_r;
    mem_we     = 1'b0;
`ifdef BSG_DMC_UI_RESPONDER_ERR_CHECK_EN
    error_n    = error_r;
`endif
    case (state_r)
      st_idle: begin
        if (app_en_i) begin
          if (app_cmd_i == cmd_write) begin
            base_n  = cmd_base;
            cnt_n   = '0;
            state_n = st_write;
          end else if (app_cmd_i == cmd_read) begin
            base_n = cmd_base;
            cnt_n  = '0;
            lat_n  = '0;
            if (rd_latency_p == 0) begin
              state_n    = st_read;
              rd_valid_n = 1'b1;
              rd_end_n   = (ui_burst_len_p == 1);
              rd_idx     = cmd_base;
            end else begin
              state_n = st_rd_wait;
            end
          end else begin
`ifdef BSG_DMC_UI_RESPONDER_ERR_CHECK_EN
            error_n = 1'b1;
`endif
          end
        end
      end
      st_write: begin
        if (app_wdf_wren_i) begin
          mem_we = 1'b1;
          cnt_n  = cnt_inc;
`ifdef BSG_DMC_UI_RESPONDER_ERR_CHECK_EN
          if (app_wdf_end_i != cnt_is_last) error_n = 1'b1;
`endif
          if (cnt_is_last) state_n = st_idle;
        end
      end
      st_rd_wait: begin
        if (lat_r == lat_w'(lat_last)) begin
          state_n    = st_read;
          rd_valid_n = 1'b1;
          rd_end_n   = (ui_burst_len_p == 1);
          rd_idx     = base_r;
        end else begin
          lat_n = lat_r + lat_w'(1);
        end
      end
      default: begin
        // cnt_r is the beat on the bus now; stage the next one
        if (cnt_is_last) begin
          state_n = st_idle;
        end else begin
          cnt_n      = cnt_inc;
          rd_valid_n = 1'b1;
          rd_end_n   = (cnt_inc == cnt_w'(cnt_last));
          rd_idx     = base_r + idx_w'(cnt_inc);
        end
      end
    endcase
    if (rd_valid_n) rd_data_n = mem[rd_idx];
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= st_idle;
    else            state_r <= state_n;
  end

  // Burst bookkeeping and registered handshake / read outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r      <= '0;
      lat_r      <= '0;
      base_r     <= '0;
      rdy_r      <= 1'b1;
      wdf_rdy_r  <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
      rd_end_r   <= 1'b0;
    end else begin
      cnt_r      <= cnt_n;
      lat_r      <= lat_n;
      base_r     <= base_n;
      rdy_r      <= (state_n == st_idle);
      wdf_rdy_r  <= (state_n == st_write);
      rd_valid_r <= rd_valid_n;
      rd_data_r  <= rd_data_n;
      rd_end_r   <= rd_end_n;
    end
  end

  // Beat memory: cleared on reset, byte-masked writes
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < int'(mem_els_p); i++) mem[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < int'(mask_w); b++) begin
        if (!app_wdf_mask_i[b]) mem[wr_idx][b*8 +: 8] <= app_wdf_data_i[b*8 +: 8];
      end
    end
  end

`ifdef BSG_DMC_UI_RESPONDER_ERR_CHECK_EN
  // Sticky protocol-error flag
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) error_r <= 1'b0;
    else            error_r <= error_n;
  end
  assign error_o = error_r;
`else
  assign error_o = 1'b0;
`endif

  assign app_rdy_o           = rdy_r;
  assign app_wdf_rdy_o       = wdf_rdy_r;
  assign app_rd_data_valid_o = rd_valid_r;
  assign app_rd_data_o       = rd_data_r;
  assign app_rd_data_end_o   = rd_end_r;

endmodule

// File: tb/tb_bsg_dmc_ui_responder.sv
// Scoreboard bench for bsg_dmc_ui_responder: one instance with read latency 3,
// one with latency 0, sharing command/write-data lines but with separate app_en.
`timescale 1ns/1ps
module tb_bsg_dmc_ui_responder;

  localparam int unsigned aw = 28;
  localparam int unsigned dw = 32;
  localparam int unsigned bl = 4;
  localparam int unsigned me = 64;
`ifdef BSG_DMC_UI_RESPONDER_ERR_CHECK_EN
  localparam logic err_en = 1'b1;
`else
  localparam logic err_en = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [aw-1:0] addr;
  logic [2:0]    cmd;
  logic          en3, en0;
  logic          wren, wend;
  logic [dw-1:0] wdata;
  logic [3:0]    wmask;

  logic          rdy3, wrdy3, rv3, rend3, err3;
  logic [dw-1:0] rdata3;
  logic          rdy0, wrdy0, rv0, rend0, err0;
  logic [dw-1:0] rdata0;

  bsg_dmc_ui_responder #(.rd_latency_p(3)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .app_addr_i(addr), .app_cmd_i(cmd), .app_en_i(en3), .app_rdy_o(rdy3),
    .app_wdf_wren_i(wren), .app_wdf_data_i(wdata), .app_wdf_mask_i(wmask),
    .app_wdf_end_i(wend), .app_wdf_rdy_o(wrdy3),
    .app_rd_data_valid_o(rv3), .app_rd_data_o(rdata3), .app_rd_data_end_o(rend3),
    .error_o(err3)
  );

  bsg_dmc_ui_responder #(.rd_latency_p(0)) dut0 (
    .clk_i(clk), .reset_n_i(reset_n),
    .app_addr_i(addr), .app_cmd_i(cmd), .app_en_i(en0), .app_rdy_o(rdy0),
    .app_wdf_wren_i(wren), .app_wdf_data_i(wdata), .app_wdf_mask_i(wmask),
    .app_wdf_end_i(wend), .app_wdf_rdy_o(wrdy0),
    .app_rd_data_valid_o(rv0), .app_rd_data_o(rdata0), .app_rd_data_end_o(rend0),
    .error_o(err0)
  );

  typedef struct {
    logic [dw-1:0] data;
    logic          last;
    int            cyc;
  } beat_t;

  beat_t         q3[$];
  beat_t         q0[$];
  beat_t         b3, b0;
  logic [dw-1:0] model [me];
  logic          err_exp;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            acc1, acc2;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int unsigned base_of(input logic [aw-1:0] a);
    int unsigned w;
    w = 32'(a) >> 2;
    return (w % me) & ~(bl - 1);
  endfunction

  // Read-beat scoreboard for both instances
  always @(negedge clk) begin
    if (reset_n) begin
      if (rv3) begin
        if (q3.size() == 0) check("rd3_unexpected", 1, 0);
        else begin
          b3 = q3.pop_front();
          check("rd3_data", rdata3, b3.data);
          check("rd3_end", rend3, b3.last);
          check("rd3_cycle", cyc, b3.cyc);
        end
      end
      if (rv0) begin
        if (q0.size() == 0) check("rd0_unexpected", 1, 0);
        else begin
          b0 = q0.pop_front();
          check("rd0_data", rdata0, b0.data);
          check("rd0_end", rend0, b0.last);
          check("rd0_cycle", cyc, b0.cyc);
        end
      end
    end
  end

  // All tasks start and end just after a rising edge
  task automatic wait_rdy(input int sel);
    int n = 0;
    while (!(((sel & 1) == 0 || rdy3) && ((sel & 2) == 0 || rdy0))) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        check("rdy_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic issue_cmd(input int sel, input logic [2:0] c, input logic [aw-1:0] a,
                           output int acc);
    wait_rdy(sel);
    cmd = c; addr = a;
    en3 = (sel & 1) != 0;
    en0 = (sel & 2) != 0;
    acc = cyc;
    @(posedge clk); #1;
    en3 = 1'b0; en0 = 1'b0;
  endtask

  task automatic write_burst(input logic [aw-1:0] a, input logic [3:0][dw-1:0] d,
                             input logic [3:0][3:0] m, input logic [3:0] endpat);
    int acc;
    int unsigned base;
    base = base_of(a);
    issue_cmd(3, 3'b000, a, acc);
    for (int k = 0; k < 4; k++) begin
      check("wdf_rdy3", wrdy3, 1);
      check("wdf_rdy0", wrdy0, 1);
      wren = 1'b1; wdata = d[k]; wmask = m[k]; wend = endpat[k];
      @(posedge clk); #1;
      for (int b = 0; b < 4; b++)
        if (!m[k][b]) model[base + k][b*8 +: 8] = d[k][b*8 +: 8];
      if (err_en && (endpat[k] != (k == 3))) err_exp = 1'b1;
      check("err3", err3, err_exp);
      check("err0", err0, err_exp);
    end
    wren = 1'b0; wend = 1'b0;
    check("rdy_after_wr3", rdy3, 1);
    check("rdy_after_wr0", rdy0, 1);
  endtask

  task automatic read_cmd(input int sel, input logic [aw-1:0] a, output int acc);
    int unsigned base;
    int lat;
    beat_t b;
    base = base_of(a);
    lat = (sel == 1) ? 3 : 0;
    wait_rdy(sel);
    cmd = 3'b001; addr = a;
    en3 = (sel == 1);
    en0 = (sel == 2);
    acc = cyc;
    for (int k = 0; k < 4; k++) begin
      b.data = model[base + k];
      b.last = (k == 3);
      b.cyc  = acc + lat + 1 + k;
      if (sel == 1) q3.push_back(b);
      else          q0.push_back(b);
    end
    @(posedge clk); #1;
    en3 = 1'b0; en0 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q3.size() != 0 || q0.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain3", q3.size(), 0);
    check("drain0", q0.size(), 0);
  endtask

  task automatic check_reset_state();
    check("rst_rdy3", rdy3, 1);     check("rst_rdy0", rdy0, 1);
    check("rst_wrdy3", wrdy3, 0);   check("rst_wrdy0", wrdy0, 0);
    check("rst_rv3", rv3, 0);       check("rst_rv0", rv0, 0);
    check("rst_rdata3", rdata3, 0); check("rst_rdata0", rdata0, 0);
    check("rst_rend3", rend3, 0);   check("rst_rend0", rend0, 0);
    check("rst_err3", err3, 0);     check("rst_err0", err0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    addr = '0; cmd = '0; en3 = 1'b0; en0 = 1'b0;
    wren = 1'b0; wend = 1'b0; wdata = '0; wmask = '0;
    err_exp = 1'b0;
    for (int i = 0; i < int'(me); i++) model[i] = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_reset_state();

    // Read of untouched memory returns zeros
    read_cmd(1, 28'h0, acc1);
    drain();

    // Basic burst write then read on both latencies
    write_burst(28'h40, {32'h44, 32'h33, 32'h22, 32'h11}, '0, 4'b1000);
    read_cmd(1, 28'h40, acc1);
    drain();
    read_cmd(2, 28'h40, acc1);
    drain();

    // Byte mask on beat 0, other beats fully masked; read via unaligned address in same burst
    write_burst(28'h40, {32'h01020304, 32'h05060708, 32'h090A0B0C, 32'hAABBCCDD},
                {4'b1111, 4'b1111, 4'b1111, 4'b1010}, 4'b1000);
    read_cmd(1, 28'h48, acc1);
    drain();

    // Address wrap-around: 0x3F0 and 0xF0 share beat base 60
    write_burst(28'h3F0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, '0, 4'b1000);
    read_cmd(1, 28'hF0, acc1);
    drain();
    read_cmd(2, 28'h3F4, acc1);
    drain();

    // Illegal command: flag (when enabled), stay ready, no memory change
    issue_cmd(3, 3'b010, 28'h40, acc1);
    if (err_en) err_exp = 1'b1;
    check("illegal_err3", err3, err_exp);
    check("illegal_err0", err0, err_exp);
    check("illegal_rdy3", rdy3, 1);
    check("illegal_rdy0", rdy0, 1);
    read_cmd(2, 28'h40, acc1);
    drain();

    // Reset while beat 2 of a read is on the bus
    read_cmd(1, 28'h40, acc1);
    while (cyc < acc1 + 6) begin
      @(posedge clk); #1;
    end
    check("mid_rv_before", rv3, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rv_after", rv3, 0);
    check("mid_rdy", rdy3, 1);
    check("mid_err", err3, 0);
    q3.delete();
    err_exp = 1'b0;
    for (int i = 0; i < int'(me); i++) model[i] = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    read_cmd(1, 28'h40, acc1);
    drain();

    // wdf_end on beat 1 (and missing on beat 3): burst still completes
    write_burst(28'h80, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, '0, 4'b0010);
    read_cmd(1, 28'h80, acc1);
    drain();
    read_cmd(2, 28'h80, acc1);
    drain();
    check("err_sticky3", err3, err_exp);

    // Back-to-back reads: next acceptance right after the last beat
    write_burst(28'h40, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, '0, 4'b1000);
    read_cmd(2, 28'h40, acc1);
    read_cmd(2, 28'h80, acc2);
    check("b2b_gap0", acc2 - acc1, bl + 1);
    drain();
    read_cmd(1, 28'h40, acc1);
    read_cmd(1, 28'h80, acc2);
    check("b2b_gap3", acc2 - acc1, 3 + bl + 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
